// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl: PS/2 mouse sequencer. Runs the power-up handshake
// (FF reset, FA ack, AA BAT, 00 ID, F4 enable, FA ack) through the ps2tx/ps2rx
// pair, then assembles 3-byte stream packets into a clamped cursor position
// and button state. Optional watchdog enabled by defining MOUSE_TIMEOUT_EN.
module ps2_mouse_ctrl #(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int X_INIT         = 6,
  parameter int Y_INIT         = 6,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] din,
  output logic [9:0] mouse_x,
  output logic [9:0] mouse_y,
  output logic [2:0] buttons,
  output logic       packet_valid,
  output logic       init_done,
  output logic       init_error
);

  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic signed [10:0] X_LIM = 11'(X_MAX);
  localparam logic signed [10:0] Y_LIM = 11'(Y_MAX);

  typedef enum logic [3:0] {
    S_SEND_FF, S_WAIT_TX_FF, S_ACK_FF, S_BAT, S_ID,
    S_SEND_F4, S_WAIT_TX_F4, S_ACK_F4,
    S_B0, S_B1, S_B2, S_FAIL
  } state_t;

  state_t               state;
  logic [RETRY_W-1:0]   retry_cnt;
  logic                 rx_ev;
  logic                 ack_state;
  logic                 init_phase;
  logic [7:0]           exp_byte;
  logic                 init_fault;
  logic                 tmo;

  // Packet bytes; b0 keeps {y_ovf, x_ovf, y_sign, x_sign, buttons[2:0]}
  logic [6:0]           b0_p0;
  logic [7:0]           b1_p0;
  logic [7:0]           b2_p0;
  logic                 vld_p0;
  logic signed [8:0]    dx_p0;
  logic signed [8:0]    dy_p0;
  logic signed [10:0]   x_sum_p0;
  logic signed [10:0]   y_sum_p0;

  // Saturate an 11-bit signed intermediate into [0, lim]
  function automatic logic [9:0] clamp(input logic signed [10:0] v,
                                       input logic signed [10:0] lim);
    if (v < 0)
      return 10'd0;
    else if (v > lim)
      return lim[9:0];
    else
      return v[9:0];
  endfunction

  // A tx completion wins over a simultaneous rx byte, which is dropped
  assign rx_ev = rx_done_tick & ~tx_done_tick;

  // Expected handshake byte for the current ack/response state
  always_comb begin
    exp_byte   = 8'hFA;
    ack_state  = 1'b0;
    case (state)
      S_ACK_FF: begin ack_state = 1'b1; exp_byte = 8'hFA; end
      S_BAT:    begin ack_state = 1'b1; exp_byte = 8'hAA; end
      S_ID:     begin ack_state = 1'b1; exp_byte = 8'h00; end
      S_ACK_F4: begin ack_state = 1'b1; exp_byte = 8'hFA; end
      default:  ;
    endcase
  end

  assign init_phase = (state != S_B0) && (state != S_B1) &&
                      (state != S_B2) && (state != S_FAIL);
  assign init_fault = (rx_ev & ack_state & (rx_dout != exp_byte)) |
                      (tmo & init_phase);

`ifdef MOUSE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  state_t           state_q;

  // Watchdog: cleared by any tick or state change, saturates at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      state_q <= S_SEND_FF;
    end else begin
      state_q <= state;
      if (rx_done_tick || tx_done_tick || (state != state_q))
        tmo_cnt <= '0;
      else if (tmo_cnt != CNT_W'(TIMEOUT_CYCLES - 1))
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
               !rx_done_tick && !tx_done_tick && (state == state_q);
`else
  assign tmo = 1'b0;
`endif

  // Control FSM: init handshake, retry bookkeeping and packet byte framing
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_SEND_FF;
      retry_cnt  <= '0;
      wr_ps2     <= 1'b0;
      din        <= 8'h00;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      vld_p0     <= 1'b0;
    end else begin
      wr_ps2 <= 1'b0;
      vld_p0 <= 1'b0;
      if (init_fault) begin
        if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
          state      <= S_FAIL;
          init_error <= 1'b1;
        end else begin
          retry_cnt <= retry_cnt + 1'b1;
          state     <= S_SEND_FF;
        end
      end else begin
        case (state)
          S_SEND_FF: if (tx_idle) begin
            wr_ps2 <= 1'b1;
            din    <= 8'hFF;
            state  <= S_WAIT_TX_FF;
          end
          S_WAIT_TX_FF: if (tx_done_tick) state <= S_ACK_FF;
          S_ACK_FF:     if (rx_ev) state <= S_BAT;
          S_BAT:        if (rx_ev) state <= S_ID;
          S_ID:         if (rx_ev) state <= S_SEND_F4;
          S_SEND_F4: if (tx_idle) begin
            wr_ps2 <= 1'b1;
            din    <= 8'hF4;
            state  <= S_WAIT_TX_F4;
          end
          S_WAIT_TX_F4: if (tx_done_tick) state <= S_ACK_F4;
          S_ACK_F4: if (rx_ev) begin
            state     <= S_B0;
            init_done <= 1'b1;
          end
          S_B0: if (rx_ev && rx_dout[3]) state <= S_B1;
          S_B1: begin
            if (tmo)        state <= S_B0;
            else if (rx_ev) state <= S_B2;
          end
          S_B2: begin
            if (tmo) state <= S_B0;
            else if (rx_ev) begin
              state  <= S_B0;
              vld_p0 <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Packet byte capture (data only, no reset)
  always_ff @(posedge clk) begin
    if (rx_ev) begin
      case (state)
        S_B0: if (rx_dout[3]) b0_p0 <= {rx_dout[7:4], rx_dout[2:0]};
        S_B1: b1_p0 <= rx_dout;
        S_B2: b2_p0 <= rx_dout;
        default: ;
      endcase
    end
  end

  // ---- stage p0 -> p1: signed displacement and position update ----
  assign dx_p0    = {b0_p0[3], b1_p0};
  assign dy_p0    = {b0_p0[4], b2_p0};
  assign x_sum_p0 = $signed({1'b0, mouse_x}) + {{2{dx_p0[8]}}, dx_p0};
  assign y_sum_p0 = $signed({1'b0, mouse_y}) - {{2{dy_p0[8]}}, dy_p0};

  // Registered cursor/button outputs with a same-cycle packet_valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      mouse_x      <= 10'(X_INIT);
      mouse_y      <= 10'(Y_INIT);
      buttons      <= 3'b000;
      packet_valid <= 1'b0;
    end else begin
      packet_valid <= vld_p0;
      if (vld_p0) begin
        if (!b0_p0[5]) mouse_x <= clamp(x_sum_p0, X_LIM);
        if (!b0_p0[6]) mouse_y <= clamp(y_sum_p0, Y_LIM);
        buttons <= b0_p0[2:0];
      end
    end
  end

endmodule
